// File: rtl/datamem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// No logic here; owner encoding and response record used by the top.
// Range helper flags any word address beyond the memory depth.
package datamem_arb_pkg;

    localparam int ADDR_W_DEF   = 7;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   err;
    } resp_t;

    function automatic logic addr_oob(input logic [31:0] addr, input int aw);
        return (addr >> aw) != 32'd0;
    endfunction

endpackage

// File: rtl/datamem_wait_ctr.sv
// Saturating DMA starvation counter; raises force_dma after MAX_WAIT denied cycles.
// Registered count, force_dma is a decode of the current count (same cycle).
// Clears whenever DMA is granted or stops requesting.
module datamem_wait_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    logic [3:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 4'd0;
        end else if (dma_req && !dma_gnt) begin
            if (wait_cnt != 4'(MAX_WAIT))
                wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end

    assign force_dma = (wait_cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/datamem_arbiter.sv
// Shares a single-port data memory between the CPU memory stage and the DMA port.
// Grant is combinational in cycle N; response (rvalid/rdata/err) follows in N+1.
// Loser sees no grant and must hold its request; flush blocks all grants.
module datamem_arbiter
    import datamem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              cpu_flush,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_clear,
    output logic              mem_hold,
    input  logic [DATA_W-1:0] mem_q
);

    logic              force_dma;
    logic              any_gnt;
    logic              sel_we;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oob;
    resp_t             resp_q;

    datamem_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .force_dma (force_dma)
    );

    // Grants are held off while reset is asserted so nothing reaches memory.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (reset_n && !cpu_flush) begin
            if (force_dma && dma_req)
                dma_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
            else if (dma_req)
                dma_gnt = 1'b1;
        end
    end

    assign any_gnt   = cpu_gnt | dma_gnt;
    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = 32'd0;
        sel_wdata = '0;
        if (cpu_gnt) begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end
    end

    assign sel_oob = any_gnt & addr_oob(sel_addr, ADDR_W);

    // Out-of-range accesses are still granted but never touch the array.
    assign mem_addr  = (any_gnt && !sel_oob) ? {{(32-ADDR_W){1'b0}}, sel_addr[ADDR_W-1:0]} : 32'd0;
    assign mem_we    = sel_we & ~sel_oob;
    assign mem_data  = sel_wdata;
    assign mem_clear = cpu_flush;
    assign mem_hold  = ~any_gnt & ~cpu_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_q <= '{owner: OWN_NONE, err: 1'b0};
        end else begin
            resp_q.owner <= cpu_gnt ? OWN_CPU : (dma_gnt ? OWN_DMA : OWN_NONE);
            resp_q.err   <= sel_oob;
        end
    end

    assign cpu_rvalid = (resp_q.owner == OWN_CPU);
    assign dma_rvalid = (resp_q.owner == OWN_DMA);
    assign cpu_err    = cpu_rvalid & resp_q.err;
    assign dma_err    = dma_rvalid & resp_q.err;
    assign cpu_rdata  = (cpu_rvalid && !resp_q.err) ? mem_q : '0;
    assign dma_rdata  = (dma_rvalid && !resp_q.err) ? mem_q : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench: arbiter plus a behavioural 128x32 registered memory with clear/hold.
module tb_datamem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, cpu_flush;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid, dma_err;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr, mem_data, mem_q;
    logic        mem_we, mem_clear, mem_hold;

    logic [31:0] mem_arr [128];

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    datamem_arbiter #(.ADDR_W(7), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .cpu_flush  (cpu_flush),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_err    (dma_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_data   (mem_data),
        .mem_clear  (mem_clear),
        .mem_hold   (mem_hold),
        .mem_q      (mem_q)
    );

    // Memory with registered q and write-through; upper address bits must be zero.
    always @(posedge clk) begin
        if (mem_clear)
            mem_q <= 32'd0;
        else if (!mem_hold) begin
            if (mem_we) begin
                mem_arr[mem_addr[6:0]] <= mem_data;
                mem_q                  <= mem_data;
            end else begin
                mem_q <= mem_arr[mem_addr[6:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_d;
        reset_n   = 1'b0;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_flush = 1'b0;
        dma_req   = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;

        // Reset state
        @(negedge clk);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("rst_mem_hold", 32'(mem_hold), 32'd1);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        cyc();
        reset_n = 1'b1;

        // CPU write then read of address 5
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd5; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("wr_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", mem_addr, 32'd5);
        chk("wr_mem_data", mem_data, 32'hDEADBEEF);
        cyc();
        chk("wr_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("wr_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("wr_err", 32'(cpu_err), 32'd0);
        chk("wr_dma_rvalid", 32'(dma_rvalid), 32'd0);
        cpu_we = 1'b0; cpu_wdata = 32'd0;
        @(negedge clk);
        chk("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rd_mem_we", 32'(mem_we), 32'd0);
        chk("rd_mem_hold", 32'(mem_hold), 32'd0);
        cyc();
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);

        // Continuous contention: DMA forced every 5th cycle
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd10; dma_wdata = 32'hA5A5A5A5;
        for (int k = 0; k < 10; k++) begin
            exp_d = (k % 5 == 4);
            @(negedge clk);
            chk("ct_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            chk("ct_cpu_gnt", 32'(cpu_gnt), 32'(!exp_d));
            chk("ct_cpu_stall", 32'(cpu_stall), 32'(exp_d));
            cyc();
            chk("ct_cpu_rvalid", 32'(cpu_rvalid), 32'(!exp_d));
            chk("ct_dma_rvalid", 32'(dma_rvalid), 32'(exp_d));
            chk("ct_cpu_rdata", cpu_rdata, exp_d ? 32'd0 : 32'hDEADBEEF);
            chk("ct_dma_rdata", dma_rdata, exp_d ? 32'hA5A5A5A5 : 32'd0);
        end
        cpu_req = 1'b0; dma_req = 1'b0; dma_we = 1'b0;

        // Out-of-range DMA write/read at 200 must not alias onto index 72
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd72; cpu_wdata = 32'h77777777;
        @(negedge clk);
        chk("oob_pre_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        chk("oob_pre_rdata", cpu_rdata, 32'h77777777);
        cpu_req = 1'b0; cpu_we = 1'b0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'd200; dma_wdata = 32'h00000055;
        @(negedge clk);
        chk("oobw_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("oobw_mem_we", 32'(mem_we), 32'd0);
        chk("oobw_mem_addr", mem_addr, 32'd0);
        cyc();
        chk("oobw_rvalid", 32'(dma_rvalid), 32'd1);
        chk("oobw_rdata", dma_rdata, 32'd0);
        chk("oobw_err", 32'(dma_err), 32'd1);
        chk("oobw_cpu_err", 32'(cpu_err), 32'd0);
        dma_we = 1'b0;
        @(negedge clk);
        chk("oobr_dma_gnt", 32'(dma_gnt), 32'd1);
        chk("oobr_mem_we", 32'(mem_we), 32'd0);
        cyc();
        chk("oobr_rvalid", 32'(dma_rvalid), 32'd1);
        chk("oobr_rdata", dma_rdata, 32'd0);
        chk("oobr_err", 32'(dma_err), 32'd1);
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_addr = 32'd72;
        @(negedge clk);
        cyc();
        chk("oob_chk_rdata", cpu_rdata, 32'h77777777);
        chk("oob_chk_err", 32'(cpu_err), 32'd0);

        // Flush with both requesting: prior response delivered, nothing after
        cpu_addr = 32'd5;
        @(negedge clk);
        chk("fl_pre_gnt", 32'(cpu_gnt), 32'd1);
        cyc();
        dma_req = 1'b1; dma_addr = 32'd10; cpu_flush = 1'b1;
        chk("fl_prior_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("fl_prior_rdata", cpu_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("fl_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("fl_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("fl_cpu_stall", 32'(cpu_stall), 32'd1);
        chk("fl_mem_clear", 32'(mem_clear), 32'd1);
        chk("fl_mem_hold", 32'(mem_hold), 32'd0);
        chk("fl_mem_we", 32'(mem_we), 32'd0);
        cyc();
        cpu_flush = 1'b0;
        chk("fl_next_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("fl_next_dma_rvalid", 32'(dma_rvalid), 32'd0);
        chk("fl_next_rdata", cpu_rdata, 32'd0);
        // The flushed cycle counted as one DMA wait, so DMA wins after three more
        for (int j = 0; j < 4; j++) begin
            exp_d = (j == 3);
            @(negedge clk);
            chk("flw_dma_gnt", 32'(dma_gnt), 32'(exp_d));
            chk("flw_cpu_gnt", 32'(cpu_gnt), 32'(!exp_d));
            cyc();
        end
        chk("flw_dma_rvalid", 32'(dma_rvalid), 32'd1);
        chk("flw_dma_rdata", dma_rdata, 32'hA5A5A5A5);
        cpu_req = 1'b0; dma_req = 1'b0;

        // Idle cycles hold the last read value
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'd20; cpu_wdata = 32'h00001234;
        @(negedge clk);
        cyc();
        cpu_we = 1'b0;
        @(negedge clk);
        cyc();
        chk("idle_rd_rdata", cpu_rdata, 32'h00001234);
        cpu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_mem_hold", 32'(mem_hold), 32'd1);
            chk("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
            cyc();
            chk("idle_rvalid", 32'(cpu_rvalid), 32'd0);
            chk("idle_mem_q", mem_q, 32'h00001234);
        end

        // Reset mid-stream with DMA wait counter at its limit
        cpu_req = 1'b1; cpu_addr = 32'd5; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'd10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mr_cpu_gnt", 32'(cpu_gnt), 32'd1);
            cyc();
        end
        chk("mr_pre_rvalid", 32'(cpu_rvalid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("mr_rst_rdata", cpu_rdata, 32'd0);
        chk("mr_rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("mr_rst_dma_gnt", 32'(dma_gnt), 32'd0);
        chk("mr_rst_mem_hold", 32'(mem_hold), 32'd1);
        cyc();
        reset_n = 1'b1;
        chk("mr_rel_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("mr_rel_dma_rvalid", 32'(dma_rvalid), 32'd0);
        @(negedge clk);
        chk("mr_first_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("mr_first_dma_gnt", 32'(dma_gnt), 32'd0);
        cyc();
        chk("mr_first_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("mr_first_rdata", cpu_rdata, 32'hDEADBEEF);
        cpu_req = 1'b0; dma_req = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
